// File: rtl/pri_enc_scan_pkg.sv
// Shared types and helpers for the sequential priority-encoder scanner.
package pri_enc_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Widest request vector popcount() accepts; callers zero-extend to this.
    localparam int MAX_N = 256;

    // Number of set bits in a request vector of any width up to MAX_N.
    function automatic int unsigned popcount(input logic [MAX_N-1:0] vec);
        int unsigned n;
        n = 0;
        for (int i = 0; i < MAX_N; i++) begin
            n += 32'(vec[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/pri_enc_scan_if.sv
// Capture-side and emit-side handshake bundle for pri_enc_scan.
interface pri_enc_scan_if #(
    parameter int N = 8
);
    localparam int W  = $clog2(N);
    localparam int CW = $clog2(N + 1);

    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_req;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_idx;
    logic          out_last;
    logic          out_none;
    logic [CW-1:0] out_cnt;

    // Request source and index consumer side.
    modport master (
        output in_valid, in_req, out_ready,
        input  in_ready, out_valid, out_idx, out_last, out_none, out_cnt
    );

    // Scanner side.
    modport slave (
        input  in_valid, in_req, out_ready,
        output in_ready, out_valid, out_idx, out_last, out_none, out_cnt
    );
endinterface

// File: rtl/pri_enc_scan_comb.sv
// Purely combinational priority encoder: winning index plus any/multi flags.
module pri_enc_comb #(
    parameter int N         = 8,
    parameter int MSB_FIRST = 1,
    localparam int W        = $clog2(N)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         any,
    output logic         multi
);

    // Walk from lowest to highest priority so the last set bit seen wins.
    always_comb begin
        // NOTE: blocking assignments here are intentional; each loop iteration
        // must see the previous iteration's any/idx, which only '=' provides.
        idx   = '0;
        any   = 1'b0;
        multi = 1'b0;
        for (int i = 0; i < N; i++) begin
            int j;
            j = (MSB_FIRST != 0) ? i : (N - 1 - i);
            if (vec[j]) begin
                multi = multi | any;
                any   = 1'b1;
                idx   = W'(j);
            end
        end
    end

endmodule

// File: rtl/pri_enc_scan.sv
// Captures a request vector and emits the index of each set bit, one per
// accepted beat, in priority order; reports popcount and the all-zero case.
module pri_enc_scan
    import pri_enc_pkg::*;
#(
    parameter int N         = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic            clk,
    input  logic            rst,
    pri_enc_scan_if.slave   bus
);
    localparam int W  = $clog2(N);
    localparam int CW = $clog2(N + 1);

    state_t        state_q, state_d;
    logic [N-1:0]  pending_q;
    logic          none_q;
    logic [CW-1:0] cnt_q;

    logic [W-1:0]  enc_idx;
    logic          enc_any;
    logic          enc_multi;
    logic [N-1:0]  clr_mask;
    logic          capture;
    logic          accept;
    logic          in_ready_c;
    logic          out_valid_c;

    // Encoder sees only the registered copy, so nothing from in_req or
    // out_ready reaches out_idx/out_last combinationally.
    pri_enc_comb #(
        .N         (N),
        .MSB_FIRST (MSB_FIRST)
    ) u_enc (
        .vec   (pending_q),
        .idx   (enc_idx),
        .any   (enc_any),
        .multi (enc_multi)
    );

    assign capture  = (state_q == IDLE) && bus.in_valid;
    assign accept   = (state_q == EMIT) && bus.out_ready;
    // An all-zero capture has no bit to clear on its single beat.
    assign clr_mask = enc_any ? (N'(1) << enc_idx) : '0;

    // State register plus captured vector, none flag and popcount.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            none_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                pending_q <= bus.in_req;
                none_q    <= (bus.in_req == '0);
                cnt_q     <= CW'(popcount(MAX_N'(bus.in_req)));
            end else if (accept) begin
                pending_q <= pending_q & ~clr_mask;
            end
        end
    end

    // Next-state and handshake decode; valid/ready depend on state only.
    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) state_d = EMIT;
            end
            EMIT: begin
                out_valid_c = 1'b1;
                if (bus.out_ready && !enc_multi) state_d = IDLE;
            end
        endcase
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_idx   = enc_idx;
    assign bus.out_last  = (state_q == EMIT) && !enc_multi;
    assign bus.out_none  = (state_q == EMIT) && none_q;
    assign bus.out_cnt   = cnt_q;

endmodule

// File: tb/tb_pri_enc_scan.sv
// Drives an MSB-first and an LSB-first scanner with identical stimulus and
// compares both against a list-based model of the captured request set.
module tb_pri_enc_scan;

    typedef struct packed {
        logic       valid;
        logic       ready;
        logic [2:0] idx;
        logic       last;
        logic       none;
        logic [3:0] cnt;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    // Model: ascending list of captured set-bit indices and beats taken so far.
    bit   m_busy = 1'b0;
    int   m_asc[$];
    int   m_k    = 0;
    int   m_cnt  = 0;
    bit   m_none = 1'b0;
    logic cur_ordy = 1'b0;

    always #5 clk = ~clk;

    pri_enc_scan_if #(.N(8)) bus_m ();
    pri_enc_scan_if #(.N(8)) bus_l ();

    pri_enc_scan #(.N(8), .MSB_FIRST(1)) dut_m (.clk(clk), .rst(rst), .bus(bus_m.slave));
    pri_enc_scan #(.N(8), .MSB_FIRST(0)) dut_l (.clk(clk), .rst(rst), .bus(bus_l.slave));

    function automatic beat_t observe(int d);
        beat_t b;
        if (d == 0) b = '{bus_m.out_valid, bus_m.in_ready, bus_m.out_idx, bus_m.out_last, bus_m.out_none, bus_m.out_cnt};
        else        b = '{bus_l.out_valid, bus_l.in_ready, bus_l.out_idx, bus_l.out_last, bus_l.out_none, bus_l.out_cnt};
        return b;
    endfunction

    function automatic beat_t exp_beat(int d);
        beat_t e;
        int    sz;
        sz      = m_asc.size();
        e       = '0;
        e.valid = m_busy;
        e.ready = !m_busy;
        e.cnt   = 4'(m_cnt);
        if (m_busy) begin
            e.last = ((sz - m_k) <= 1);
            e.none = m_none;
            if (!m_none) e.idx = 3'((d == 0) ? m_asc[sz - 1 - m_k] : m_asc[m_k]);
        end
        return e;
    endfunction

    // One clock: drive inputs, take the edge, advance the model.
    task automatic cycle(input logic r, input logic iv, input logic [7:0] req, input logic ordy);
        rst = r;
        bus_m.in_valid = iv;  bus_l.in_valid = iv;
        bus_m.in_req   = req; bus_l.in_req   = req;
        bus_m.out_ready = ordy; bus_l.out_ready = ordy;
        cur_ordy = ordy;
        @(posedge clk);
        if (r) begin
            m_busy = 0; m_asc.delete(); m_k = 0; m_cnt = 0; m_none = 0;
        end else if (!m_busy) begin
            if (iv) begin
                m_asc.delete();
                for (int i = 0; i < 8; i++) if (req[i]) m_asc.push_back(i);
                m_busy = 1; m_k = 0; m_cnt = m_asc.size(); m_none = (req == 8'h00);
            end
        end else if (ordy) begin
            m_k++;
            if (m_k >= ((m_asc.size() > 0) ? m_asc.size() : 1)) m_busy = 0;
        end
        cyc++;
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (m_busy && n < 20) begin
            cycle(0, 0, 8'h00, 1);
            n++;
        end
        if (m_busy) begin
            checks++; failures++;
            $display("FAIL drain timeout busy=%0d required=0", m_busy);
        end
    endtask

    task automatic test_reset();
        cycle(1, 1, 8'hFF, 1);
        cycle(1, 1, 8'hFF, 1);
        for (int c = 0; c < 2; c++) begin
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (observe(d) !== exp_beat(d)) begin
                    failures++;
                    $display("FAIL reset dut=%0d cyc=%0d got=%h required=%h", d, cyc, observe(d), exp_beat(d));
                end
            end
            cycle(0, 0, 8'h00, 1);
        end
    endtask

    task automatic test_single();
        cycle(0, 1, 8'h80, 1);
        for (int c = 0; c < 3; c++) begin
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (observe(d) !== exp_beat(d)) begin
                    failures++;
                    $display("FAIL single dut=%0d cyc=%0d got=%h required=%h", d, cyc, observe(d), exp_beat(d));
                end
            end
            cycle(0, 0, 8'h00, 1);
        end
    endtask

    task automatic test_pattern();
        int got_m[$];
        int got_l[$];
        int want_m[$];
        int want_l[$];
        bit ok;
        want_m = '{7, 5, 2, 0};
        want_l = '{0, 2, 5, 7};
        cycle(0, 1, 8'hA5, 1);
        for (int c = 0; c < 6; c++) begin
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (observe(d) !== exp_beat(d)) begin
                    failures++;
                    $display("FAIL pattern dut=%0d cyc=%0d got=%h required=%h", d, cyc, observe(d), exp_beat(d));
                end
            end
            if (bus_m.out_valid) got_m.push_back(int'(bus_m.out_idx));
            if (bus_l.out_valid) got_l.push_back(int'(bus_l.out_idx));
            cycle(0, 0, 8'h00, 1);
        end
        ok = (got_m.size() == 4) && (got_l.size() == 4);
        if (ok) for (int i = 0; i < 4; i++) if (got_m[i] != want_m[i] || got_l[i] != want_l[i]) ok = 0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL pattern_order got_msb=%p got_lsb=%p required 7,5,2,0 / 0,2,5,7", got_m, got_l);
        end
    endtask

    task automatic test_zero();
        cycle(0, 1, 8'h00, 1);
        for (int c = 0; c < 3; c++) begin
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (observe(d) !== exp_beat(d)) begin
                    failures++;
                    $display("FAIL zero dut=%0d cyc=%0d got=%h required=%h", d, cyc, observe(d), exp_beat(d));
                end
            end
            cycle(0, 0, 8'h00, 1);
        end
    endtask

    task automatic test_stall();
        int   beats;
        int   c;
        logic ordy;
        logic iv;
        beats = 0;
        c = 0;
        cycle(0, 1, 8'hFF, 1);
        while (m_busy && c < 40) begin
            ordy = ((c % 3) == 0);
            iv   = (m_k < 6) ? 1'($urandom_range(0, 1)) : 1'b0;
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (observe(d) !== exp_beat(d)) begin
                    failures++;
                    $display("FAIL stall dut=%0d cyc=%0d got=%h required=%h", d, cyc, observe(d), exp_beat(d));
                end
            end
            if (bus_m.out_valid && ordy) beats++;
            cycle(0, iv, 8'($urandom), ordy);
            c++;
        end
        checks++;
        if (beats != 8 || m_busy) begin
            failures++;
            $display("FAIL stall_beats got=%0d required=8 busy=%0d", beats, m_busy);
        end
    endtask

    task automatic test_reset_mid();
        cycle(0, 1, 8'hFF, 1);
        cycle(0, 0, 8'h00, 1);
        cycle(0, 0, 8'h00, 1);
        cycle(1, 1, 8'h55, 1);
        for (int c = 0; c < 3; c++) begin
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (observe(d) !== exp_beat(d)) begin
                    failures++;
                    $display("FAIL reset_mid dut=%0d cyc=%0d got=%h required=%h", d, cyc, observe(d), exp_beat(d));
                end
            end
            cycle(0, (c == 0), 8'h02, 1);
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 40; c++) begin
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (observe(d) !== exp_beat(d)) begin
                    failures++;
                    $display("FAIL back_to_back dut=%0d cyc=%0d got=%h required=%h", d, cyc, observe(d), exp_beat(d));
                end
            end
            cycle(0, 1, 8'($urandom), 1'($urandom_range(0, 3) != 0));
        end
        drain();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (observe(d) !== exp_beat(d)) begin
                    failures++;
                    $display("FAIL random dut=%0d cyc=%0d got=%h required=%h", d, cyc, observe(d), exp_beat(d));
                end
            end
            cycle(($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom),
                  1'($urandom_range(0, 1)));
        end
        drain();
    endtask

    initial begin
        bus_m.in_valid = 0; bus_l.in_valid = 0;
        bus_m.in_req = '0;  bus_l.in_req = '0;
        bus_m.out_ready = 0; bus_l.out_ready = 0;
        test_reset();
        test_single();
        test_pattern();
        test_zero();
        test_stall();
        drain();
        test_reset_mid();
        drain();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
